// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage MIPS core, with
// load-use hazard detection.
//
// Each clock the decoded control, operands and register addresses from ID are
// captured and presented to EX. A load sitting in EX whose destination feeds
// the instruction in ID raises Stall. Stall holds the PC and IF/ID, and this
// stage inserts a bubble. Flush squashes the incoming instruction. Freeze
// holds everything as it is.
//
// Update priority on each edge: reset > Freeze > Flush > Stall > load.
//
// Optional feature, enabled by defining ID_EX_STALL_CNT_EN:
//   Adds output StallCnt[CNT_W-1:0]. It is a saturating count of bubbles
//   caused by Stall alone, not counting edges where Flush or Freeze is active.

module id_ex_stage #(
    parameter int DATA_W    = 32,
    parameter int ALUCODE_W = 5
`ifdef ID_EX_STALL_CNT_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Freeze,
    input  logic                 Flush,

    // Decoded control from ID
    input  logic                 RegWrite_id,
    input  logic                 MemRead_id,
    input  logic                 MemWrite_id,
    input  logic                 MemToReg_id,
    input  logic                 RegDst_id,
    input  logic                 ALUSrcA_id,
    input  logic                 ALUSrcB_id,
    input  logic [ALUCODE_W-1:0] ALUCode_id,
    input  logic                 RtRead_id,

    // Operands and register addresses from ID
    input  logic [DATA_W-1:0]    Imm_id,
    input  logic [DATA_W-1:0]    Sa_id,
    input  logic [4:0]           RsAddr_id,
    input  logic [4:0]           RtAddr_id,
    input  logic [4:0]           RdAddr_id,
    input  logic [DATA_W-1:0]    RsData_id,
    input  logic [DATA_W-1:0]    RtData_id,

    // Registered control to EX
    output logic                 RegWrite_ex,
    output logic                 MemRead_ex,
    output logic                 MemWrite_ex,
    output logic                 MemToReg_ex,
    output logic                 RegDst_ex,
    output logic                 ALUSrcA_ex,
    output logic                 ALUSrcB_ex,
    output logic [ALUCODE_W-1:0] ALUCode_ex,

    // Registered operands and addresses to EX
    output logic [DATA_W-1:0]    Imm_ex,
    output logic [DATA_W-1:0]    Sa_ex,
    output logic [DATA_W-1:0]    RsData_ex,
    output logic [DATA_W-1:0]    RtData_ex,
    output logic [4:0]           RsAddr_ex,
    output logic [4:0]           RtAddr_ex,
    output logic [4:0]           RdAddr_ex,

`ifdef ID_EX_STALL_CNT_EN
    output logic [CNT_W-1:0]     StallCnt,
`endif
    output logic                 Stall
);

    // Every field carried from ID to EX. An all-zero value is a NOP bubble:
    // nothing is written, nothing is accessed in memory, and the destination
    // resolves to $0.
    typedef struct packed {
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 mem_to_reg;
        logic                 reg_dst;
        logic                 alu_src_a;
        logic                 alu_src_b;
        logic [ALUCODE_W-1:0] alu_code;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    sa;
        logic [DATA_W-1:0]    rs_data;
        logic [DATA_W-1:0]    rt_data;
        logic [4:0]           rs_addr;
        logic [4:0]           rt_addr;
        logic [4:0]           rd_addr;
    } ex_fields_t;

    ex_fields_t id_fields;
    ex_fields_t ex_d;
    ex_fields_t ex_q;
    logic       stall;

    // Gather the ID-side inputs into one record.
    always_comb begin
        id_fields = '{
            reg_write:  RegWrite_id,
            mem_read:   MemRead_id,
            mem_write:  MemWrite_id,
            mem_to_reg: MemToReg_id,
            reg_dst:    RegDst_id,
            alu_src_a:  ALUSrcA_id,
            alu_src_b:  ALUSrcB_id,
            alu_code:   ALUCode_id,
            imm:        Imm_id,
            sa:         Sa_id,
            rs_data:    RsData_id,
            rt_data:    RtData_id,
            rs_addr:    RsAddr_id,
            rt_addr:    RtAddr_id,
            rd_addr:    RdAddr_id
        };
    end

    // Load-use hazard: a load in EX writes a register that the ID instruction
    // reads. Rt counts as a source only when ID says so.
    always_comb begin
        stall = 1'b0;
        if (ex_q.mem_read && (ex_q.rt_addr != 5'd0)) begin
            stall = (ex_q.rt_addr == RsAddr_id) ||
                    (RtRead_id && (ex_q.rt_addr == RtAddr_id));
        end
    end

    // Next EX contents. Freeze holds. Flush or Stall inserts a bubble.
    // Otherwise the ID instruction is loaded.
    always_comb begin
        // NOTE: the default-first assignment covers every path through the
        // block, so no latch is inferred. Blocking '=' is correct here in
        // combinational code; the flop below uses '<='.
        ex_d = ex_q;
        if (!Freeze) begin
            if (Flush || stall) begin
                ex_d = '0;
            end else begin
                ex_d = id_fields;
            end
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign RegWrite_ex = ex_q.reg_write;
    assign MemRead_ex  = ex_q.mem_read;
    assign MemWrite_ex = ex_q.mem_write;
    assign MemToReg_ex = ex_q.mem_to_reg;
    assign RegDst_ex   = ex_q.reg_dst;
    assign ALUSrcA_ex  = ex_q.alu_src_a;
    assign ALUSrcB_ex  = ex_q.alu_src_b;
    assign ALUCode_ex  = ex_q.alu_code;
    assign Imm_ex      = ex_q.imm;
    assign Sa_ex       = ex_q.sa;
    assign RsData_ex   = ex_q.rs_data;
    assign RtData_ex   = ex_q.rt_data;
    assign RsAddr_ex   = ex_q.rs_addr;
    assign RtAddr_ex   = ex_q.rt_addr;
    assign RdAddr_ex   = ex_q.rd_addr;

    // Stall is independent of Freeze and Flush. Upstream holds whenever the
    // hazard is present.
    assign Stall = stall;

`ifdef ID_EX_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    // Count only bubbles caused by Stall alone, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!Freeze && !Flush && stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: testbench for the id_ex_stage pipeline register.
// It applies a table of directed vectors, then a few hand-written multi-cycle
// sequences, then randomized traffic checked against a behavioural model.

module tb_id_ex_stage;

    // One instruction's worth of ID/EX fields. Control bit order is
    // {reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src_a, alu_src_b}.
    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_dst;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [4:0]  alu_code;
        logic [31:0] imm;
        logic [31:0] sa;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
    } fields_t;

    // Directed vector: inputs applied before an edge, Stall expected before
    // that edge, EX contents expected after it.
    typedef struct {
        logic    rst;
        logic    frz;
        logic    fl;
        fields_t id;
        logic    rt_read;
        logic    exp_stall;
        fields_t exp_ex;
    } vec_t;

    localparam logic [6:0] C_ALU = 7'b1000100;  // R-type: write Rd
    localparam logic [6:0] C_IMM = 7'b1000001;  // I-type ALU: write Rt, B = Imm
    localparam logic [6:0] C_LD  = 7'b1101001;  // load
    localparam logic [6:0] C_ST  = 7'b0010001;  // store
    localparam logic [6:0] C_RWW = 7'b1010000;  // RegWrite + MemWrite (flush check)

    logic clk;
    logic rst, frz, fl, rt_read;
    fields_t id_in;

    logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex;
    logic        RegDst_ex, ALUSrcA_ex, ALUSrcB_ex;
    logic [4:0]  ALUCode_ex;
    logic [31:0] Imm_ex, Sa_ex, RsData_ex, RtData_ex;
    logic [4:0]  RsAddr_ex, RtAddr_ex, RdAddr_ex;
    logic        Stall;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] StallCnt;
`endif

    fields_t act_ex;
    int      n_cmp = 0;
    int      n_fail = 0;
    vec_t    tbl[$];

    id_ex_stage dut (
        .clk        (clk),
        .reset      (rst),
        .Freeze     (frz),
        .Flush      (fl),
        .RegWrite_id(id_in.reg_write),
        .MemRead_id (id_in.mem_read),
        .MemWrite_id(id_in.mem_write),
        .MemToReg_id(id_in.mem_to_reg),
        .RegDst_id  (id_in.reg_dst),
        .ALUSrcA_id (id_in.alu_src_a),
        .ALUSrcB_id (id_in.alu_src_b),
        .ALUCode_id (id_in.alu_code),
        .RtRead_id  (rt_read),
        .Imm_id     (id_in.imm),
        .Sa_id      (id_in.sa),
        .RsAddr_id  (id_in.rs_addr),
        .RtAddr_id  (id_in.rt_addr),
        .RdAddr_id  (id_in.rd_addr),
        .RsData_id  (id_in.rs_data),
        .RtData_id  (id_in.rt_data),
        .RegWrite_ex(RegWrite_ex),
        .MemRead_ex (MemRead_ex),
        .MemWrite_ex(MemWrite_ex),
        .MemToReg_ex(MemToReg_ex),
        .RegDst_ex  (RegDst_ex),
        .ALUSrcA_ex (ALUSrcA_ex),
        .ALUSrcB_ex (ALUSrcB_ex),
        .ALUCode_ex (ALUCode_ex),
        .Imm_ex     (Imm_ex),
        .Sa_ex      (Sa_ex),
        .RsData_ex  (RsData_ex),
        .RtData_ex  (RtData_ex),
        .RsAddr_ex  (RsAddr_ex),
        .RtAddr_ex  (RtAddr_ex),
        .RdAddr_ex  (RdAddr_ex),
`ifdef ID_EX_STALL_CNT_EN
        .StallCnt   (StallCnt),
`endif
        .Stall      (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb act_ex = {RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex, RegDst_ex,
                          ALUSrcA_ex, ALUSrcB_ex, ALUCode_ex, Imm_ex, Sa_ex,
                          RsData_ex, RtData_ex, RsAddr_ex, RtAddr_ex, RdAddr_ex};

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic fields_t mk(input logic [6:0] ctrl, input logic [4:0] code,
                                   input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [31:0] base);
        fields_t f;
        {f.reg_write, f.mem_read, f.mem_write, f.mem_to_reg,
         f.reg_dst, f.alu_src_a, f.alu_src_b} = ctrl;
        f.alu_code = code;
        f.imm      = base ^ 32'hFFFF_0000;
        f.sa       = {27'd0, base[4:0]};
        f.rs_data  = base + 32'd1;
        f.rt_data  = base + 32'd2;
        f.rs_addr  = rs;
        f.rt_addr  = rt;
        f.rd_addr  = rd;
        return f;
    endfunction

    function automatic fields_t rand_fields();
        logic [159:0] raw;
        fields_t f;
        raw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        f = raw[154:0];
        f.mem_read = 1'($urandom_range(0, 1));
        f.rs_addr  = 5'($urandom_range(0, 3));
        f.rt_addr  = 5'($urandom_range(0, 3));
        return f;
    endfunction

    task automatic add(input logic r, input logic f, input logic l, input fields_t id,
                       input logic rtr, input logic es, input fields_t ee);
        vec_t v;
        v.rst = r; v.frz = f; v.fl = l; v.id = id; v.rt_read = rtr;
        v.exp_stall = es; v.exp_ex = ee;
        tbl.push_back(v);
    endtask

    // Drive one cycle, check Stall before the edge and EX contents after it.
    task automatic step(input string nm, input logic r, input logic f, input logic l,
                        input fields_t id, input logic rtr, input logic chk_stall,
                        input logic exp_stall, input fields_t exp_ex);
        @(negedge clk);
        rst = r; frz = f; fl = l; id_in = id; rt_read = rtr;
        #1;
        if (chk_stall) check({nm, ".stall"}, 160'(Stall), 160'(exp_stall));
        @(posedge clk);
        #1;
        check({nm, ".ex"}, 160'(act_ex), 160'(exp_ex));
    endtask

    initial begin : main
        fields_t i_nrm, ld8, use8, ld0, z0, ld9, nr9, ld10, st10, ld11, u11, fwr;
        fields_t ld12, u12, lda, ldb, zero;
        fields_t model_ex, rid, nxt;
        logic    r, f, l, rtr, hz;
        int      model_cnt;

        zero = '0;
        rst = 1'b1; frz = 1'b0; fl = 1'b0; rt_read = 1'b0; id_in = '0;

        // Reset held two cycles with random ID inputs.
        step("reset0", 1'b1, 1'b0, 1'b0, rand_fields(), 1'b1, 1'b0, 1'b0, zero);
        step("reset1", 1'b1, 1'b0, 1'b0, rand_fields(), 1'b1, 1'b1, 1'b0, zero);

        i_nrm = mk(C_ALU, 5'h02, 5'd1, 5'd2, 5'd3, 32'h0);
        i_nrm.rs_data = 32'h11;
        i_nrm.imm     = 32'hFFFF_FFF0;
        ld8  = mk(C_LD,  5'h00, 5'd4,  5'd8,  5'd0,  32'h100);
        use8 = mk(C_ALU, 5'h03, 5'd8,  5'd5,  5'd6,  32'h200);
        ld0  = mk(C_LD,  5'h00, 5'd7,  5'd0,  5'd0,  32'h300);
        z0   = mk(C_ALU, 5'h04, 5'd0,  5'd0,  5'd1,  32'h400);
        ld9  = mk(C_LD,  5'h00, 5'd2,  5'd9,  5'd0,  32'h500);
        nr9  = mk(C_IMM, 5'h05, 5'd3,  5'd9,  5'd0,  32'h580);
        ld10 = mk(C_LD,  5'h00, 5'd1,  5'd10, 5'd0,  32'h600);
        st10 = mk(C_ST,  5'h00, 5'd1,  5'd10, 5'd0,  32'h700);
        ld11 = mk(C_LD,  5'h00, 5'd2,  5'd11, 5'd0,  32'h780);
        u11  = mk(C_ALU, 5'h06, 5'd11, 5'd2,  5'd3,  32'h800);
        fwr  = mk(C_RWW, 5'h07, 5'd12, 5'd13, 5'd14, 32'h900);
        ld12 = mk(C_LD,  5'h00, 5'd3,  5'd12, 5'd0,  32'hA00);
        u12  = mk(C_ALU, 5'h08, 5'd12, 5'd4,  5'd5,  32'hB00);
        lda  = mk(C_LD,  5'h00, 5'd1,  5'd15, 5'd0,  32'hC00);
        ldb  = mk(C_LD,  5'h00, 5'd15, 5'd16, 5'd0,  32'hD00);

        //   rst   frz   fl    id    rt_rd stall exp_ex
        add(1'b0, 1'b0, 1'b0, i_nrm, 1'b1, 1'b0, i_nrm);  // normal flow
        add(1'b0, 1'b0, 1'b0, ld8,   1'b0, 1'b0, ld8);
        add(1'b0, 1'b0, 1'b0, use8,  1'b1, 1'b1, zero);   // load-use on Rs -> bubble
        add(1'b0, 1'b0, 1'b0, use8,  1'b1, 1'b0, use8);   // held instruction loads
        add(1'b0, 1'b0, 1'b0, ld0,   1'b0, 1'b0, ld0);
        add(1'b0, 1'b0, 1'b0, z0,    1'b1, 1'b0, z0);     // load to $0: no stall
        add(1'b0, 1'b0, 1'b0, ld9,   1'b0, 1'b0, ld9);
        add(1'b0, 1'b0, 1'b0, nr9,   1'b0, 1'b0, nr9);    // Rt match, RtRead=0
        add(1'b0, 1'b0, 1'b0, ld10,  1'b0, 1'b0, ld10);
        add(1'b0, 1'b0, 1'b0, st10,  1'b1, 1'b1, zero);   // load-use on Rt
        add(1'b0, 1'b0, 1'b0, st10,  1'b1, 1'b0, st10);
        add(1'b0, 1'b0, 1'b0, ld11,  1'b0, 1'b0, ld11);
        add(1'b0, 1'b1, 1'b0, u11,   1'b1, 1'b1, ld11);   // freeze during hazard x3
        add(1'b0, 1'b1, 1'b0, u11,   1'b1, 1'b1, ld11);
        add(1'b0, 1'b1, 1'b0, u11,   1'b1, 1'b1, ld11);
        add(1'b0, 1'b0, 1'b0, u11,   1'b1, 1'b1, zero);   // release -> bubble
        add(1'b0, 1'b0, 1'b0, u11,   1'b1, 1'b0, u11);
        add(1'b0, 1'b0, 1'b1, fwr,   1'b1, 1'b0, zero);   // flush squashes writes
        add(1'b0, 1'b0, 1'b0, ld12,  1'b0, 1'b0, ld12);
        add(1'b0, 1'b0, 1'b1, u12,   1'b1, 1'b1, zero);   // flush + stall
        add(1'b0, 1'b0, 1'b0, u12,   1'b1, 1'b0, u12);
        add(1'b0, 1'b0, 1'b0, lda,   1'b0, 1'b0, lda);
        add(1'b0, 1'b0, 1'b0, ldb,   1'b0, 1'b1, zero);   // back-to-back loads
        add(1'b0, 1'b0, 1'b0, ldb,   1'b0, 1'b0, ldb);
        add(1'b0, 1'b0, 1'b0, i_nrm, 1'b1, 1'b0, i_nrm);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].frz, tbl[i].fl, tbl[i].id,
                 tbl[i].rt_read, 1'b1, tbl[i].exp_stall, tbl[i].exp_ex);
        end
`ifdef ID_EX_STALL_CNT_EN
        check("stall_cnt_table", 160'(StallCnt), 160'(4));
`endif

        // Reset asserted during a stall cycle clears EX and drops Stall.
        step("mid_ld", 1'b0, 1'b0, 1'b0, ld8, 1'b0, 1'b1, 1'b0, ld8);
        step("mid_rst", 1'b1, 1'b0, 1'b0, use8, 1'b1, 1'b1, 1'b1, zero);
        check("mid_rst.stall_after", 160'(Stall), 160'(0));
`ifdef ID_EX_STALL_CNT_EN
        check("mid_rst.cnt", 160'(StallCnt), 160'(0));
`endif

        // Randomized traffic against the behavioural model.
        model_ex  = '0;
        model_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            rid = rand_fields();
            r   = (i == 0) || ($urandom_range(0, 63) == 0);
            f   = ($urandom_range(0, 7) == 0);
            l   = ($urandom_range(0, 7) == 0);
            rtr = 1'($urandom_range(0, 1));
            hz  = model_ex.mem_read && (model_ex.rt_addr != 5'd0) &&
                  ((model_ex.rt_addr == rid.rs_addr) ||
                   (rtr && (model_ex.rt_addr == rid.rt_addr)));
            if (r)            nxt = '0;
            else if (f)       nxt = model_ex;
            else if (l || hz) nxt = '0;
            else              nxt = rid;
            if (r)                               model_cnt = 0;
            else if (!f && !l && hz && model_cnt < 65535) model_cnt++;
            step($sformatf("rnd%0d", i), r, f, l, rid, rtr, 1'b1, hz, nxt);
            model_ex = nxt;
        end
`ifdef ID_EX_STALL_CNT_EN
        check("stall_cnt_rand", 160'(StallCnt), 160'(model_cnt));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core. Captures decoded control, operands and register addresses from ID each cycle and presents them as the *_ex signals consumed by the EX stage. Detects a load in EX whose destination is a source of the instruction in ID. On that hazard it asserts Stall, which holds the PC and IF/ID, and inserts a bubble into EX. Also supports a flush input and a global freeze input.

Parameters:
DATA_W, 32, operand/immediate width
ALUCODE_W, 5, ALU operation code width
CNT_W, 16, stall counter width (only with the optional feature)

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high
Freeze  input  1  global pipeline hold (e.g. memory wait); register keeps contents
Flush  input  1  squash the instruction entering EX (branch/jump redirect)
RegWrite_id  input  1  control from decode
MemRead_id  input  1  instruction is a load
MemWrite_id  input  1  instruction is a store
MemToReg_id  input  1  writeback selects memory data
RegDst_id  input  1  dest = Rd (1) / Rt (0)
ALUSrcA_id  input  1  ALU A = Sa
ALUSrcB_id  input  1  ALU B = Imm
ALUCode_id  input  ALUCODE_W  ALU operation
RtRead_id  input  1  instruction reads Rt as a source (R-type, store, branch)
Imm_id  input  DATA_W  extended immediate
Sa_id  input  DATA_W  zero-extended shift amount
RsAddr_id, RtAddr_id, RdAddr_id  input  5 each  register addresses
RsData_id, RtData_id  input  DATA_W each  register file read data
RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex, RegDst_ex, ALUSrcA_ex, ALUSrcB_ex  output  1 each  registered control
ALUCode_ex  output  ALUCODE_W  registered ALU op
Imm_ex, Sa_ex, RsData_ex, RtData_ex  output  DATA_W each  registered data
RsAddr_ex, RtAddr_ex, RdAddr_ex  output  5 each  registered addresses
Stall  output  1  combinational load-use stall to PC and IF/ID

Behaviour:
- Hazard: Stall = MemRead_ex && (RtAddr_ex != 0) && ((RtAddr_ex == RsAddr_id) || (RtRead_id && RtAddr_ex == RtAddr_id)). Purely combinational from registered EX fields and ID inputs. Stall does not depend on Freeze or Flush.
- Register update on each rising clk edge, with priority reset > Freeze > Flush > Stall > load:
  - reset: every registered output is cleared to 0.
  - Freeze: all registers hold their values; nothing is lost, and no bubble is inserted.
  - Flush: all registered outputs are cleared to 0 (a bubble). This is a NOP, because RegWrite/MemRead/MemWrite are 0 and RegWriteAddr resolves to $0.
  - Stall: a bubble is inserted, identical to Flush.
  - Otherwise: every *_id input is captured into its *_ex output.
- Latency: 1 cycle from ID to EX.
- Load-use costs exactly one bubble. After the bubble, MemRead_ex = 0, so Stall deasserts, and the held ID instruction loads on the next edge. EX then receives the load result through the MEM/WB forwarding path.
- Load with destination $0: no stall.
- Two back-to-back loads where the second uses the first: one stall.
- Reset asserted mid-stall: outputs clear on that edge and Stall drops to 0 in the same cycle.
- Flush and Stall together: the result is a bubble either way. Flush has priority only for the counter feature.

Optional Feature:
ID_EX_STALL_CNT_EN. When defined:
- An extra output StallCnt (CNT_W) is present. It is a saturating count of bubbles inserted because of Stall, excluding edges where Flush or Freeze is active.
- It saturates at all-ones.
- reset clears it to 0.

When undefined, the port and logic are absent, and the behaviour above is unchanged.

Test Plan:
1. Reset: hold reset 2 cycles with random *_id inputs -> all *_ex = 0, Stall = 0.
2. Normal flow: ALUCode_id=5'h02, RsData_id=32'h11, Imm_id=32'hFFFF_FFF0 -> the next edge shows the same values on *_ex, Stall = 0.
3. Load-use: load with RtAddr_ex=8 in EX, ID has RsAddr_id=8 -> Stall=1 for 1 cycle, next-cycle *_ex all 0. Next edge loads the ID instruction, Stall=0. Counter (if enabled) = 1.
4. No false stall: load RtAddr_ex=0 and RsAddr_id=0 -> Stall=0. Load RtAddr_ex=9, RtAddr_id=9 with RtRead_id=0 -> Stall=0.
5. Freeze: Freeze=1 for 3 cycles during a load-use hazard -> *_ex unchanged, Stall stays 1. After release -> bubble, then a normal load.
6. Flush: Flush=1 with RegWrite_id=1, MemWrite_id=1 -> next-cycle RegWrite_ex=0, MemWrite_ex=0, all data outputs 0.
